banked_memory: RTL and testbench

BANKED_MEMORY -- requirements
Module: banked_memory

---
 rtl/memory_pkg.sv | 17 +
 rtl/arilla_bus_if.sv | 29 ++
 rtl/memory_bank.sv | 36 +++
 rtl/banked_memory.sv | 194 +++++++++++++++++++
 tb/tb_banked_memory.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/memory_pkg.sv
// Shared constants and helpers for the banked memory slice.
`timescale 1ns/1ps
package memory_pkg;

  localparam int unsigned ByteSize       = 8;
  localparam int unsigned WordW          = 32;
  localparam int unsigned BytesPerWord   = WordW / ByteSize;
  localparam int unsigned WordAddrW      = 30;
  localparam int unsigned MaxBanks       = 8;
  localparam int unsigned MaxReadLatency = 4;

  // Even parity bit for one byte: byte plus bit holds an even number of ones.
  function automatic logic even_parity(input logic [ByteSize-1:0] i_byte);
    return ^i_byte;
  endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Word-addressed bus with a shared tristate data lane.
`timescale 1ns/1ps
interface arilla_bus_if;
  import memory_pkg::*;

  logic [WordAddrW-1:0]    address;
  logic [BytesPerWord-1:0] byte_enable;
  logic                    read;
  logic                    write;
  logic                    intercept;
  logic [WordW-1:0]        wdata;
  logic [WordW-1:0]        rdata;
  logic                    rdata_oe;
  wire  [WordW-1:0]        data;

  // Shared data lane: slave return has priority, master drives it on writes.
  assign data = rdata_oe ? rdata : (write ? wdata : 'z);

  modport master (
    output address, byte_enable, read, write, intercept, wdata,
    input  rdata_oe, data
  );

  modport slave (
    input  address, byte_enable, read, write, intercept, wdata,
    output rdata, rdata_oe
  );

endinterface

// File: rtl/memory_bank.sv
// Single-port byte-enabled RAM bank, read-first, one-cycle registered read.
`timescale 1ns/1ps
module memory_bank #(
  parameter int unsigned RowW  = 8,
  parameter int unsigned Lanes = 4,
  parameter int unsigned LaneW = 8
) (
  input  logic                   clk,
  input  logic                   i_rd,
  input  logic                   i_wr,
  input  logic [Lanes-1:0]       i_be,
  input  logic [RowW-1:0]        i_row,
  input  logic [Lanes*LaneW-1:0] i_wdata,
  output logic [Lanes*LaneW-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << RowW;

  logic [Lanes*LaneW-1:0] r_mem [Depth];
  logic [Lanes*LaneW-1:0] r_rdata;

  // Read returns the old word when a write hits the same row this edge.
  always_ff @(posedge clk) begin
    if (i_rd) begin
      r_rdata <= r_mem[i_row];
    end
    for (int l = 0; l < Lanes; l++) begin
      if (i_wr && i_be[l]) begin
        r_mem[i_row][l*LaneW +: LaneW] <= i_wdata[l*LaneW +: LaneW];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_memory.sv
// Word-interleaved banked memory on an arilla bus with fixed read latency.
// Optional per-byte even parity: define MEMORY_PARITY_EN.
// InitFile names a preload image; per-bank slices are applied by the RAM
// macro flow, this block only carries and sanity-checks the name.
`timescale 1ns/1ps
module banked_memory
  import memory_pkg::*;
#(
  parameter logic [31:0] BaseAddress = 32'h0,
  parameter int unsigned SizeBytes   = 524288,
  parameter int unsigned Banks       = 1,
  parameter int unsigned ReadLatency = 1,
  parameter string       InitFile    = "UNUSED"
) (
  input  logic         clk,
  input  logic         rst,
  arilla_bus_if.slave  bus_interface,
  output logic         parity_error
);

  localparam int unsigned SizeLog2 = $clog2(SizeBytes);
  localparam int unsigned WordOffW = $clog2(BytesPerWord);
  localparam int unsigned LocalW   = SizeLog2 - WordOffW;
  localparam int unsigned BankLog2 = $clog2(Banks);
  localparam int unsigned BankSelW = (BankLog2 == 0) ? 1 : BankLog2;
  localparam int unsigned RowW     = LocalW - BankLog2;
`ifdef MEMORY_PARITY_EN
  localparam int unsigned ParW     = 1;
`else
  localparam int unsigned ParW     = 0;
`endif
  localparam int unsigned LaneW    = ByteSize + ParW;
  localparam int unsigned StoreW   = BytesPerWord * LaneW;
  localparam int unsigned PipeW    = StoreW + ParW * BytesPerWord;

  if (Banks < 1 || Banks > MaxBanks || (Banks & (Banks - 1)) != 0) begin : g_bad_banks
    $error("banked_memory: Banks must be a power of two in 1..8");
  end
  if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("banked_memory: ReadLatency must be in 1..4");
  end
  if (InitFile == "") begin : g_bad_init
    $error("banked_memory: InitFile must be a path or UNUSED");
  end

  logic                 w_hit;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [LocalW-1:0]    w_local;
  logic [BankSelW-1:0]  w_bank;
  logic [RowW-1:0]      w_row;
  logic [StoreW-1:0]    w_wr_store;
  logic [StoreW-1:0]    w_bank_q [Banks];
  logic [StoreW-1:0]    w_mux;
  logic [PipeW-1:0]     w_mux_ext;
  logic [PipeW-1:0]     w_ret;
  logic [WordW-1:0]     w_rdata;
  logic                 w_ret_vld;

  logic [ReadLatency-1:0] r_vld;
  logic [BankSelW-1:0]    r_bidx;

  // Address decode: region hit, bank from low word bits, row from the rest.
  assign w_hit    = (bus_interface.address[WordAddrW-1:LocalW] == BaseAddress[31:SizeLog2]);
  assign w_local  = bus_interface.address[LocalW-1:0];
  assign w_bank   = BankSelW'(w_local & LocalW'(Banks - 1));
  assign w_row    = RowW'(w_local >> BankLog2);
  assign w_rd_acc = !rst && w_hit && bus_interface.read;
  assign w_wr_acc = !rst && w_hit && bus_interface.write;

  // Pack write bytes into stored lanes, appending parity when enabled.
  always_comb begin
    w_wr_store = '0;
    for (int l = 0; l < BytesPerWord; l++) begin
`ifdef MEMORY_PARITY_EN
      w_wr_store[l*LaneW +: LaneW] = {even_parity(bus_interface.wdata[l*ByteSize +: ByteSize]),
                                      bus_interface.wdata[l*ByteSize +: ByteSize]};
`else
      w_wr_store[l*LaneW +: LaneW] = bus_interface.wdata[l*ByteSize +: ByteSize];
`endif
    end
  end

  for (genvar b = 0; b < Banks; b++) begin : g_bank
    memory_bank #(
      .RowW  (RowW),
      .Lanes (BytesPerWord),
      .LaneW (LaneW)
    ) u_bank (
      .clk     (clk),
      .i_rd    (w_rd_acc && (w_bank == BankSelW'(b))),
      .i_wr    (w_wr_acc && (w_bank == BankSelW'(b))),
      .i_be    (bus_interface.byte_enable),
      .i_row   (w_row),
      .i_wdata (w_wr_store),
      .o_rdata (w_bank_q[b])
    );
  end

  // In-flight read tracking; reset drops every read still in the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      for (int k = 1; k < ReadLatency; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

`ifdef MEMORY_PARITY_EN
  logic [BytesPerWord-1:0] r_be0;

  // Remember which bank and lanes the accepted read addressed.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_bidx <= w_bank;
      r_be0  <= bus_interface.byte_enable;
    end
  end

  assign w_mux_ext = {r_be0, w_mux};
`else
  // Remember which bank the accepted read addressed.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_bidx <= w_bank;
    end
  end

  assign w_mux_ext = w_mux;
`endif

  assign w_mux = w_bank_q[r_bidx];

  if (ReadLatency == 1) begin : g_lat1
    assign w_ret = w_mux_ext;
  end else begin : g_latn
    logic [PipeW-1:0] r_dq [ReadLatency-1];

    // Extra latency as output register stages after the bank mux.
    always_ff @(posedge clk) begin
      r_dq[0] <= w_mux_ext;
      for (int k = 1; k < ReadLatency - 1; k++) begin
        r_dq[k] <= r_dq[k-1];
      end
    end

    assign w_ret = r_dq[ReadLatency-2];
  end

  // Strip parity bits to recover the returned data word.
  always_comb begin
    w_rdata = '0;
    for (int l = 0; l < BytesPerWord; l++) begin
      w_rdata[l*ByteSize +: ByteSize] = w_ret[l*LaneW +: ByteSize];
    end
  end

  assign w_ret_vld              = r_vld[ReadLatency-1];
  assign bus_interface.rdata    = w_rdata;
  assign bus_interface.rdata_oe = w_ret_vld && !bus_interface.intercept;

`ifdef MEMORY_PARITY_EN
  logic w_par_bad;
  logic r_parity_error;

  // Check parity of every enabled lane of the returned word.
  always_comb begin
    w_par_bad = 1'b0;
    for (int l = 0; l < BytesPerWord; l++) begin
      if (w_ret[StoreW + l] &&
          (w_ret[l*LaneW + ByteSize] != even_parity(w_ret[l*LaneW +: ByteSize]))) begin
        w_par_bad = 1'b1;
      end
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_error <= 1'b0;
    end else if (bus_interface.rdata_oe && w_par_bad) begin
      r_parity_error <= 1'b1;
    end
  end

  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench for banked_memory (Banks=4, ReadLatency=3).
// Define MEMORY_PARITY_EN to also exercise the parity fault path.
`timescale 1ns/1ps
module tb_banked_memory;

  localparam int unsigned L      = 3;
  localparam logic [29:0] WBase  = 30'h400;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    bit          drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        parity_error;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          exp_perr = 1'b0;
  bit          finish_req = 1'b0;
  exp_t        q[$];
  exp_t        m_e;

  arilla_bus_if bus ();

  banked_memory #(
    .BaseAddress (32'h0000_1000),
    .SizeBytes   (4096),
    .Banks       (4),
    .ReadLatency (L),
    .InitFile    ("UNUSED")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_interface (bus),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, cycle=%0d", cyc);
    $fatal(1);
  end

  // Monitor: pops expectations exactly on their due cycle.
  always @(negedge clk) begin
    n_cmp++;
    if (parity_error !== exp_perr) begin
      n_fail++;
      $display("FAIL parity_error cyc=%0d got=%b want=%b", cyc, parity_error, exp_perr);
    end
    if (q.size() != 0 && q[0].due == cyc) begin
      m_e = q.pop_front();
      n_cmp++;
      if (m_e.drop) begin
        if (bus.rdata_oe !== 1'b0) begin
          n_fail++;
          $display("FAIL dropped_slot cyc=%0d got oe=%b want oe=0", cyc, bus.rdata_oe);
        end
      end else if (bus.rdata_oe !== 1'b1 || bus.data !== m_e.data) begin
        n_fail++;
        $display("FAIL read_data cyc=%0d got oe=%b data=%h want oe=1 data=%h",
                 cyc, bus.rdata_oe, bus.data, m_e.data);
      end
    end else if (bus.rdata_oe !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_drive cyc=%0d got oe=%b data=%h want oe=0", cyc, bus.rdata_oe, bus.data);
    end
    if (finish_req) begin
      n_cmp++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL pending_reads got=%0d want=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input bit rd_i, input bit wr_i, input logic [29:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    bus.read        = rd_i;
    bus.write       = wr_i;
    bus.address     = a;
    bus.byte_enable = be;
    bus.wdata       = d;
  endtask

  task automatic push(input logic [31:0] e, input bit drop);
    exp_t x;
    x.due  = cyc + L;
    x.data = e;
    x.drop = drop;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    set_bus(1'b0, 1'b0, '0, '0, '0);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    set_bus(1'b0, 1'b1, a, be, d);
    tick();
  endtask

  task automatic rd(input logic [29:0] a, input logic [31:0] e, input bit drop);
    set_bus(1'b1, 1'b0, a, 4'hF, '0);
    push(e, drop);
    tick();
  endtask

  task automatic rdwr(input logic [29:0] a, input logic [31:0] d, input logic [31:0] e);
    set_bus(1'b1, 1'b1, a, 4'hF, d);
    push(e, 1'b0);
    tick();
  endtask

  task automatic rd_miss(input logic [29:0] a);
    set_bus(1'b1, 1'b0, a, 4'hF, '0);
    tick();
  endtask

  initial begin
    bus.intercept = 1'b0;
    set_bus(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // Word 5 lives in bank 1 (row 1); read right after the write.
    wr(WBase + 30'd5, 4'hF, 32'hDEADBEEF);
    rd(WBase + 30'd5, 32'hDEADBEEF, 1'b0);
    idle(4);

    // Byte-lane merge.
    wr(WBase + 30'd9, 4'hF, 32'h11223344);
    wr(WBase + 30'd9, 4'b0010, 32'h0000AA00);
    rd(WBase + 30'd9, 32'h1122AA44, 1'b0);
    idle(4);

    // Fill words 0..7 then stream them back on consecutive cycles.
    for (int i = 0; i < 8; i++) wr(WBase + 30'(i), 4'hF, 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) rd(WBase + 30'(i), 32'hA000_0000 + 32'(i), 1'b0);
    idle(4);

    // Same-cycle read+write sees old data; next-cycle read sees new data.
    rdwr(WBase + 30'd2, 32'h5555_5555, 32'hA000_0002);
    rd(WBase + 30'd2, 32'h5555_5555, 1'b0);
    idle(4);

    // Misses leave memory and the bus alone.
    wr(30'h003, 4'hF, 32'hFFFF_FFFF);
    rd_miss(30'h003);
    rd(WBase + 30'd3, 32'hA000_0003, 1'b0);
    idle(4);

    // Intercept discards the first return slot only.
    rd(WBase + 30'd0, 32'h0, 1'b1);
    rd(WBase + 30'd1, 32'hA000_0001, 1'b0);
    idle(1);
    bus.intercept = 1'b1;
    tick();
    bus.intercept = 1'b0;
    idle(4);

    // Reset one cycle after two accepted reads; a write under reset is ignored.
    rd(WBase + 30'd6, 32'h0, 1'b1);
    rd(WBase + 30'd7, 32'h0, 1'b1);
    rst = 1'b1;
    wr(WBase + 30'd6, 4'hF, 32'h0BAD_0BAD);
    rst = 1'b0;
    idle(4);
    rd(WBase + 30'd6, 32'hA000_0006, 1'b0);
    rd(WBase + 30'd7, 32'hA000_0007, 1'b0);
    idle(4);

`ifdef MEMORY_PARITY_EN
    // Corrupt the stored parity of lane 0 in word 5 (bank 1, row 1).
    wr(WBase + 30'd5, 4'hF, 32'hDEADBEEF);
    idle(1);
    dut.g_bank[1].u_bank.r_mem[1][8] = ~dut.g_bank[1].u_bank.r_mem[1][8];
    rd(WBase + 30'd5, 32'hDEADBEEF, 1'b0);
    idle(3);
    exp_perr = 1'b1;
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_perr = 1'b0;
    idle(3);
`endif

    idle(4);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    finish_req = 1'b1;
  end

endmodule
